scroll_text14: RTL and testbench
================================

SCROLL_TEXT14 -- requirements
Module: scroll_text14

Interface
REQ-001 SHALL have parameter SCROLL_DIV, default 24'd6000000, the number of clk cycles per scroll step (legal range 1..2^24-1).
REQ-002 SHALL have port clk, input, 1 bit, the single clock for all logic.
REQ-003 SHALL have port rst, input, 1 bit; reset is asynchronous and active-high.
REQ-004 SHALL have port wr_en, input, 1 bit, the message-buffer write strobe.
REQ-005 SHALL have port wr_addr, input, 5 bits, the buffer write address (0..31).
REQ-006 SHALL have port wr_data, input, 6 bits, the character code to write.
REQ-007 SHALL have port msg_len, input, 6 bits, the message length in characters.
REQ-008 SHALL have port scroll_en, input, 1 bit; 1 enables scrolling.
REQ-009 SHALL have port digit_idx, input, 4 bits, the digit being scanned by the downstream 12-digit 14-segment multiplexer.
REQ-010 SHALL have port glyph, output reg, 14 bits, the segment pattern for the requested digit.
REQ-011 SHALL have port msg_wrap, output reg, 1 bit, a one-cycle pulse when the scroll offset wraps to 0.

Function
REQ-012 SHALL hold a 32x6 character buffer; on wr_en, buf[wr_addr] <= wr_data on the clk rising edge.
REQ-013 SHALL give a read of an address written in the same cycle the old buffer contents.
REQ-014 SHALL map character codes as follows: 0 = space, 1..26 = A..Z, 27..36 = digits 0..9; codes 37..63 SHALL map to blank (all zeros).
REQ-015 SHALL use these mandatory glyphs (bit 13 first):
- space = 00000000000000
- A = 11101111000000
- C = 10011100000000
- I = 10010000010010
- R = 11001111000100
- S = 10110111000000
- T = 10000000010010
- 0 = 11111100001001
- 3 = 11110001000000
The remaining glyphs SHALL follow the team glyph table.
REQ-016 SHALL compute an effective length L = min(msg_len, 32).
REQ-017 SHALL make the character index for digit d as follows:
- L >= 12: idx = offset + d, minus L if idx >= L (a single subtraction).
- L < 12: idx = d, and digits d >= L are blank.
REQ-018 SHALL register glyph with 1-cycle latency: glyph at edge n+1 = glyph_of(buf[idx(digit_idx sampled at edge n)]).
REQ-019 SHALL output glyph = 0 the next cycle when digit_idx > 11 or L == 0.
REQ-020 SHALL run a 24-bit prescaler while scroll_en = 1 and L >= 12; it counts 0..SCROLL_DIV-1, and a step request is raised at terminal count.
REQ-021 SHALL hold the prescaler at its value while scroll_en = 0; it SHALL clear to 0 while L < 12.
REQ-022 SHALL latch a pending step request and apply it only in a cycle where digit_idx == 11, so that each scan frame is tear-free.
REQ-023 SHALL perform a step as offset <= offset + 1, or 0 if offset + 1 >= L.
REQ-024 SHALL raise msg_wrap for exactly that one cycle when a step wraps offset to 0.
REQ-025 SHALL merge a second step request that arrives while one is pending into it (no queueing beyond one).
REQ-026 SHALL compare msg_len with its registered previous value; on a change, offset, the pending step and the prescaler SHALL clear to 0 in the next cycle, and msg_wrap SHALL not pulse.
REQ-027 SHALL keep offset in 0..L-1 at all times; L < 12 forces offset = 0.
REQ-028 SHALL give a wr_en to any address no effect on offset or the prescaler.

Reset
REQ-029 SHALL on rst = 1 asynchronously clear glyph to 0, msg_wrap to 0, offset to 0, the prescaler to 0, the pending step to 0, the previous-msg_len register to 0, and all buffer entries to 0 (space).
REQ-030 SHALL keep all state at reset values while rst = 1; operation SHALL resume on the first clk edge after deassertion.
REQ-031 SHALL abandon any scroll step in progress when rst asserts mid-operation, with no msg_wrap pulse.

Verification
REQ-032 Load: write codes I,S,R,A,T,I,S,C,A,0,0,3 (9,19,18,1,20,9,19,3,1,27,27,30) to addr 0..11, msg_len = 12, scroll_en = 0, sweep digit_idx 0..11 -> glyph sequence = I,S,R,A,T,I,S,C,A,0,0,3 patterns, each 1 cycle after its index.
REQ-033 Scroll: SCROLL_DIV = 4, msg_len = 14 (addr 12,13 = space), scroll_en = 1, digit_idx cycling 0..11 -> offset advances 1 per frame after each terminal count; digit 0 shows S after the first step; msg_wrap pulses once when offset goes 13 -> 0.
REQ-034 Short message: msg_len = 5, scroll_en = 1 -> digits 0..4 show buf[0..4], digits 5..11 = 0, offset stays 0, msg_wrap never pulses.
REQ-035 Boundary: digit_idx = 12..15 -> glyph = 0; code 40 in buf -> blank; msg_len = 40 -> behaves as L = 32.
REQ-036 Length change and write collision: mid-scroll change msg_len 14 -> 13 -> offset = 0 next cycle, no wrap pulse; write addr 0 while digit_idx = 0 with offset 0 -> old glyph that cycle, new glyph on the next read.
REQ-037 Reset mid-operation: assert rst asynchronously between edges during scrolling -> glyph = 0 and msg_wrap = 0 immediately; after release, digit reads are all blank until new writes.

Source files
------------

// File: rtl/scroll_text14.sv
// Scrolling message source for a 12-digit 14-segment display: 32-char buffer,
// registered glyph lookup per scanned digit, and frame-aligned scroll stepping.
module scroll_text14 #(
    parameter logic [23:0] SCROLL_DIV = 24'd6000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [4:0]  wr_addr,
    input  logic [5:0]  wr_data,
    input  logic [5:0]  msg_len,
    input  logic        scroll_en,
    input  logic [3:0]  digit_idx,
    output logic [13:0] glyph,
    output logic        msg_wrap
);

    function automatic logic [13:0] glyph_of(input logic [5:0] code);
        logic [13:0] g;
        case (code)
            6'd1:  g = 14'b11101111000000; // A
            6'd2:  g = 14'b11110001010010;
            6'd3:  g = 14'b10011100000000; // C
            6'd4:  g = 14'b11110000010010;
            6'd5:  g = 14'b10011110000000;
            6'd6:  g = 14'b10001110000000;
            6'd7:  g = 14'b10111101000000;
            6'd8:  g = 14'b01101111000000;
            6'd9:  g = 14'b10010000010010; // I
            6'd10: g = 14'b01111000000000;
            6'd11: g = 14'b00001110001100;
            6'd12: g = 14'b00011100000000;
            6'd13: g = 14'b01101100101000;
            6'd14: g = 14'b01101100100100;
            6'd15: g = 14'b11111100000000;
            6'd16: g = 14'b11001111000000;
            6'd17: g = 14'b11111100000100;
            6'd18: g = 14'b11001111000100; // R
            6'd19: g = 14'b10110111000000; // S
            6'd20: g = 14'b10000000010010; // T
            6'd21: g = 14'b01111100000000;
            6'd22: g = 14'b00001100001001;
            6'd23: g = 14'b01101100000101;
            6'd24: g = 14'b00000000101101;
            6'd25: g = 14'b00000000101010;
            6'd26: g = 14'b10010000001001;
            6'd27: g = 14'b11111100001001; // 0
            6'd28: g = 14'b01100000001000;
            6'd29: g = 14'b11011011000000;
            6'd30: g = 14'b11110001000000; // 3
            6'd31: g = 14'b01100111000000;
            6'd32: g = 14'b10110111000000;
            6'd33: g = 14'b10111111000000;
            6'd34: g = 14'b11100000000000;
            6'd35: g = 14'b11111111000000;
            6'd36: g = 14'b11110111000000;
            default: g = '0;
        endcase
        return g;
    endfunction

    logic [5:0]  char_q [32];
    logic [5:0]  char_d [32];
    logic [4:0]  offset_q, offset_d;
    logic [23:0] presc_q, presc_d;
    logic        pend_q, pend_d;
    logic [5:0]  len_prev_q, len_prev_d;
    logic [13:0] glyph_q, glyph_d;
    logic        wrap_q, wrap_d;

    logic [5:0]  eff_len;
    logic        long_msg;
    logic [5:0]  sum;
    logic [4:0]  rd_idx;
    logic        blank;
    logic        len_chg;
    logic        presc_tc;
    logic        apply;
    logic        step_req;

    always_comb begin
        eff_len  = (msg_len > 6'd32) ? 6'd32 : msg_len;
        long_msg = (eff_len >= 6'd12);
        sum      = {1'b0, offset_q} + {2'b00, digit_idx};
        // offset < L and digit < 12 <= L, so one subtraction suffices
        if (long_msg) begin
            rd_idx = (sum >= eff_len) ? 5'(sum - eff_len) : sum[4:0];
        end else begin
            rd_idx = {1'b0, digit_idx};
        end
        blank = (digit_idx > 4'd11) || (eff_len == 6'd0) ||
                (!long_msg && ({2'b00, digit_idx} >= eff_len));
        glyph_d = blank ? '0 : glyph_of(char_q[rd_idx]);
    end

    always_comb begin
        presc_d    = presc_q;
        pend_d     = pend_q;
        offset_d   = offset_q;
        wrap_d     = 1'b0;
        step_req   = 1'b0;
        len_prev_d = msg_len;
        len_chg    = (msg_len != len_prev_q);
        presc_tc   = (presc_q == SCROLL_DIV - 24'd1);
        apply      = pend_q && (digit_idx == 4'd11);
        if (len_chg || !long_msg) begin
            presc_d  = '0;
            pend_d   = 1'b0;
            offset_d = '0;
        end else begin
            step_req = scroll_en && presc_tc;
            if (scroll_en) begin
                presc_d = presc_tc ? '0 : presc_q + 24'd1;
            end
            // steps land only on the last scanned digit so a frame never tears
            if (apply) begin
                if ({1'b0, offset_q} + 6'd1 >= eff_len) begin
                    offset_d = '0;
                    wrap_d   = 1'b1;
                end else begin
                    offset_d = offset_q + 5'd1;
                end
            end
            pend_d = (pend_q && !apply) || step_req;
        end
    end

    always_comb begin
        char_d = char_q;
        if (wr_en) begin
            char_d[wr_addr] = wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            char_q     <= '{default: '0};
            offset_q   <= '0;
            presc_q    <= '0;
            pend_q     <= 1'b0;
            len_prev_q <= '0;
            glyph_q    <= '0;
            wrap_q     <= 1'b0;
        end else begin
            char_q     <= char_d;
            offset_q   <= offset_d;
            presc_q    <= presc_d;
            pend_q     <= pend_d;
            len_prev_q <= len_prev_d;
            glyph_q    <= glyph_d;
            wrap_q     <= wrap_d;
        end
    end

    assign glyph    = glyph_q;
    assign msg_wrap = wrap_q;

endmodule

// File: tb/tb_scroll_text14.sv
// Bench for scroll_text14: behavioural reference model compared every cycle,
// plus directed scenarios with hand-computed literal glyph expectations.
module tb_scroll_text14;

    localparam int DIV = 4;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [5:0]  wr_data;
    logic [5:0]  msg_len;
    logic        scroll_en;
    logic [3:0]  digit_idx;
    logic [13:0] glyph;
    logic        msg_wrap;

    scroll_text14 #(.SCROLL_DIV(24'd4)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .msg_len(msg_len), .scroll_en(scroll_en),
        .digit_idx(digit_idx), .glyph(glyph), .msg_wrap(msg_wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int wrap_cnt = 0;
    bit chk_en = 1'b0;

    // reference model state
    int          m_mem [32];
    int          m_off = 0;
    int          m_cnt = 0;
    bit          m_pend = 1'b0;
    int          m_prev = 0;
    logic [13:0] exp_glyph = '0;
    logic        exp_wrap = 1'b0;

    function automatic logic [13:0] gtab(input int c);
        case (c)
            0:  return 14'b00000000000000;
            1:  return 14'b11101111000000;
            2:  return 14'b11110001010010;
            3:  return 14'b10011100000000;
            4:  return 14'b11110000010010;
            5:  return 14'b10011110000000;
            6:  return 14'b10001110000000;
            7:  return 14'b10111101000000;
            8:  return 14'b01101111000000;
            9:  return 14'b10010000010010;
            10: return 14'b01111000000000;
            11: return 14'b00001110001100;
            12: return 14'b00011100000000;
            13: return 14'b01101100101000;
            14: return 14'b01101100100100;
            15: return 14'b11111100000000;
            16: return 14'b11001111000000;
            17: return 14'b11111100000100;
            18: return 14'b11001111000100;
            19: return 14'b10110111000000;
            20: return 14'b10000000010010;
            21: return 14'b01111100000000;
            22: return 14'b00001100001001;
            23: return 14'b01101100000101;
            24: return 14'b00000000101101;
            25: return 14'b00000000101010;
            26: return 14'b10010000001001;
            27: return 14'b11111100001001;
            28: return 14'b01100000001000;
            29: return 14'b11011011000000;
            30: return 14'b11110001000000;
            31: return 14'b01100111000000;
            32: return 14'b10110111000000;
            33: return 14'b10111111000000;
            34: return 14'b11100000000000;
            35: return 14'b11111111000000;
            36: return 14'b11110111000000;
            default: return 14'b00000000000000;
        endcase
    endfunction

    function automatic int eff_len(input int ml);
        return (ml > 32) ? 32 : ml;
    endfunction

    function automatic logic [13:0] ref_glyph(input int d, input int ml, input int off);
        int l;
        l = eff_len(ml);
        if (d > 11 || l == 0) return '0;
        if (l < 12) return (d >= l) ? 14'b0 : gtab(m_mem[d]);
        return gtab(m_mem[(off + d) % l]);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_off     <= 0;
            m_cnt     <= 0;
            m_pend    <= 1'b0;
            m_prev    <= 0;
            exp_glyph <= '0;
            exp_wrap  <= 1'b0;
            for (int i = 0; i < 32; i++) m_mem[i] <= 0;
        end else begin
            exp_glyph <= ref_glyph(int'(digit_idx), int'(msg_len), m_off);
            exp_wrap  <= 1'b0;
            if (int'(msg_len) != m_prev || eff_len(int'(msg_len)) < 12) begin
                m_off  <= 0;
                m_pend <= 1'b0;
                m_cnt  <= 0;
            end else begin
                if (scroll_en) m_cnt <= (m_cnt + 1) % DIV;
                if (m_pend && digit_idx == 4'd11) begin
                    m_off    <= (m_off + 1) % eff_len(int'(msg_len));
                    exp_wrap <= ((m_off + 1) % eff_len(int'(msg_len))) == 0;
                end
                m_pend <= (m_pend && digit_idx != 4'd11) || (scroll_en && m_cnt == DIV - 1);
            end
            m_prev <= int'(msg_len);
            if (wr_en) m_mem[wr_addr] <= int'(wr_data);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            checks = checks + 1;
            if (glyph !== exp_glyph) begin
                failures = failures + 1;
                $display("FAIL model_glyph t=%0t got=%b expected=%b", $time, glyph, exp_glyph);
            end
            checks = checks + 1;
            if (msg_wrap !== exp_wrap) begin
                failures = failures + 1;
                $display("FAIL model_wrap t=%0t got=%b expected=%b", $time, msg_wrap, exp_wrap);
            end
            if (msg_wrap === 1'b1) wrap_cnt = wrap_cnt + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s t=%0t got=%0h expected=%0h", name, $time, act, exp);
        end
    endtask

    task automatic write_char(input int addr, input int data);
        wr_addr = 5'(addr);
        wr_data = 6'(data);
        wr_en   = 1'b1;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    int          codes [12] = '{9, 19, 18, 1, 20, 9, 19, 3, 1, 27, 27, 30};
    logic [13:0] load_exp [12] = '{
        14'b10010000010010, 14'b10110111000000, 14'b11001111000100, 14'b11101111000000,
        14'b10000000010010, 14'b10010000010010, 14'b10110111000000, 14'b10011100000000,
        14'b11101111000000, 14'b11111100001001, 14'b11111100001001, 14'b11110001000000};
    localparam logic [13:0] G_S = 14'b10110111000000;
    localparam logic [13:0] G_I = 14'b10010000010010;
    localparam logic [13:0] G_A = 14'b11101111000000;
    int lens [10] = '{0, 5, 11, 12, 13, 14, 31, 32, 40, 63};

    initial begin
        int o_at;
        int w0;
        bit s_seen;
        int d;
        rst = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        msg_len = '0; scroll_en = 1'b0; digit_idx = '0;
        #3 rst = 1'b1;
        chk_en = 1'b1;
        #1;
        chk("reset_glyph", 32'(glyph), 32'd0);
        chk("reset_wrap", 32'(msg_wrap), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // load and sweep
        msg_len = 6'd12;
        for (int i = 0; i < 12; i++) write_char(i, codes[i]);
        for (int i = 0; i < 12; i++) begin
            digit_idx = 4'(i);
            @(negedge clk);
            chk("load_glyph", 32'(glyph), 32'(load_exp[i]));
        end

        // out-of-range digits and an unmapped code
        for (int i = 12; i < 16; i++) begin
            digit_idx = 4'(i);
            @(negedge clk);
            chk("digit_oob", 32'(glyph), 32'd0);
        end
        write_char(5, 40);
        digit_idx = 4'd5;
        @(negedge clk);
        chk("code40_blank", 32'(glyph), 32'd0);
        write_char(5, 9);

        // scroll over a 14-char message
        write_char(12, 0);
        write_char(13, 0);
        msg_len = 6'd14;
        scroll_en = 1'b1;
        w0 = wrap_cnt;
        s_seen = 1'b0;
        for (int i = 0; i < 240; i++) begin
            digit_idx = 4'(i % 12);
            o_at = m_off;
            @(negedge clk);
            if (i % 12 == 0 && o_at == 1 && !s_seen) begin
                s_seen = 1'b1;
                chk("scroll_d0_S", 32'(glyph), 32'(G_S));
            end
        end
        chk("scroll_saw_step", 32'(s_seen), 32'd1);
        chk("scroll_wrap_count", 32'(wrap_cnt - w0), 32'd1);

        // length change mid-scroll resets offset without a wrap
        w0 = wrap_cnt;
        msg_len = 6'd13;
        digit_idx = 4'd5;
        @(negedge clk);
        digit_idx = 4'd0;
        @(negedge clk);
        chk("lenchg_offset0", 32'(glyph), 32'(G_I));
        chk("lenchg_nowrap", 32'(wrap_cnt - w0), 32'd0);

        // write collision at the read address
        scroll_en = 1'b0;
        msg_len = 6'd12;
        @(negedge clk);
        wr_addr = 5'd0; wr_data = 6'd1; wr_en = 1'b1; digit_idx = 4'd0;
        @(negedge clk);
        chk("collide_old", 32'(glyph), 32'(G_I));
        wr_en = 1'b0;
        @(negedge clk);
        chk("collide_new", 32'(glyph), 32'(G_A));
        write_char(0, 9);

        // short message never scrolls
        msg_len = 6'd5;
        scroll_en = 1'b1;
        w0 = wrap_cnt;
        for (int i = 0; i < 120; i++) begin
            digit_idx = 4'(i % 12);
            @(negedge clk);
            if (i % 12 >= 5) chk("short_blank", 32'(glyph), 32'd0);
        end
        chk("short_nowrap", 32'(wrap_cnt - w0), 32'd0);

        // asynchronous reset during scrolling
        msg_len = 6'd14;
        for (int i = 0; i < 40; i++) begin
            digit_idx = 4'(i % 12);
            @(negedge clk);
        end
        digit_idx = 4'd1;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_glyph", 32'(glyph), 32'd0);
        chk("midrst_wrap", 32'(msg_wrap), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        msg_len = 6'd12;
        scroll_en = 1'b0;
        for (int i = 0; i < 12; i++) begin
            digit_idx = 4'(i);
            @(negedge clk);
            chk("postrst_blank", 32'(glyph), 32'd0);
        end

        // randomized traffic against the model
        for (int i = 0; i < 32; i++) write_char(i, int'($urandom_range(0, 40)));
        msg_len = 6'd40;
        d = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) d = int'($urandom_range(0, 15));
            else d = (d + 1) % 12;
            digit_idx = 4'(d);
            scroll_en = ($urandom_range(0, 15) != 0);
            wr_en   = ($urandom_range(0, 3) == 0);
            wr_addr = 5'($urandom_range(0, 31));
            wr_data = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 511) == 0) msg_len = 6'(lens[$urandom_range(0, 9)]);
            @(negedge clk);
        end
        wr_en = 1'b0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
